// File: rtl/cap_switch_router.sv
// cap_switch_router
//   Registered router from CHANNEL_NUM channel lanes onto CAPACITOR_NUM
//   capacitor slots. The k-th set bit of the active mask (counting from the
//   LSB) carries channel k; unselected slots are driven with zero.
//   New masks are adopted through a load handshake with popcount checking
//   and a break-before-make sequence: all slots are forced to zero for the
//   dead time before the new map is switched in.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   data_in      channel data, channel i = [i*WIDTH +: WIDTH]
//   sw_in        requested capacitor mask (sampled with sw_load in IDLE)
//   sw_load      request to adopt sw_in
//   sw_busy      reconfiguration in progress
//   sw_err       one-cycle pulse for a rejected load (wrong popcount)
//   sw_active    capacitor mask currently in force
//   data_out_FF  registered capacitor data, slot j = [j*WIDTH +: WIDTH]
module cap_switch_router #(
    parameter int WIDTH         = 8,
    parameter int CHANNEL_NUM   = 70,
    parameter int CAPACITOR_NUM = 128,
    parameter int BBM_CYCLES    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [WIDTH*CHANNEL_NUM-1:0]     data_in,
    input  logic [CAPACITOR_NUM-1:0]         sw_in,
    input  logic                             sw_load,
    output logic                             sw_busy,
    output logic                             sw_err,
    output logic [CAPACITOR_NUM-1:0]         sw_active,
    output logic [WIDTH*CAPACITOR_NUM-1:0]   data_out_FF
);

    localparam int RW = $clog2(CHANNEL_NUM + 1);
    localparam int CW = (BBM_CYCLES > 1) ? $clog2(BBM_CYCLES) : 1;
    localparam logic [RW-1:0] CN_R     = RW'(CHANNEL_NUM);
    localparam logic [CW-1:0] CNT_LAST = CW'(BBM_CYCLES - 1);
    localparam logic [CAPACITOR_NUM-1:0] RST_MASK =
        {CAPACITOR_NUM{1'b1}} >> (CAPACITOR_NUM - CHANNEL_NUM);

    typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_MAKE} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [CAPACITOR_NUM-1:0]       shadow_q, shadow_d;
    logic [CAPACITOR_NUM-1:0]       active_q, active_d;
    logic                           busy_q, busy_d;
    logic                           err_q, err_d;
    logic [WIDTH*CAPACITOR_NUM-1:0] data_q, data_d;
    logic [RW-1:0]                  rank_q     [CAPACITOR_NUM];
    logic [RW-1:0]                  rank_new_d [CAPACITOR_NUM];
    logic [WIDTH*CAPACITOR_NUM-1:0] route_d;
    logic                           mask_ok;

    assign mask_ok = ($countones(sw_in) == CHANNEL_NUM);

    // Control FSM: load acceptance, dead-time counter, mask switch-over
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        active_d = active_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sw_load) begin
                    if (mask_ok) begin
                        shadow_d = sw_in;
                        cnt_d    = '0;
                        state_d  = ST_BREAK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_MAKE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_MAKE: begin
                active_d = shadow_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Busy stays high for the IDLE cycle right after MAKE so the
        // outside sees one continuous busy window covering both zero phases.
        busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
    end

    // Prefix popcount of the shadow mask: rank of each slot in the new map
    always_comb begin
        logic [RW-1:0] acc;
        acc = '0;
        for (int j = 0; j < CAPACITOR_NUM; j++) begin
            rank_new_d[j] = acc;
            acc = acc + RW'(shadow_q[j]);
        end
    end

    // Slot j takes channel rank(j) when selected; the rank bound check keeps
    // the part-select in range for unselected slots.
    always_comb begin
        route_d = '0;
        for (int j = 0; j < CAPACITOR_NUM; j++) begin
            if (active_q[j] && (rank_q[j] < CN_R)) begin
                route_d[j*WIDTH +: WIDTH] = data_in[int'(rank_q[j])*WIDTH +: WIDTH];
            end
        end
        data_d = (state_q == ST_IDLE) ? route_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= RST_MASK;
            active_q <= RST_MASK;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
            data_q   <= '0;
            for (int j = 0; j < CAPACITOR_NUM; j++) begin
                rank_q[j] <= (j < CHANNEL_NUM) ? RW'(j) : CN_R;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            data_q   <= data_d;
            if (state_q == ST_MAKE) begin
                for (int j = 0; j < CAPACITOR_NUM; j++) begin
                    rank_q[j] <= rank_new_d[j];
                end
            end
        end
    end

    assign sw_busy     = busy_q;
    assign sw_err      = err_q;
    assign sw_active   = active_q;
    assign data_out_FF = data_q;

endmodule

// File: tb/tb_cap_switch_router.sv
module tb_cap_switch_router;

    localparam int W   = 8;
    localparam int CN  = 70;
    localparam int CAP = 128;
    localparam int B   = 4;
    localparam logic [CAP-1:0] LOWER = {CAP{1'b1}} >> (CAP - CN);

    logic                 clk;
    logic                 rst_n;
    logic [W*CN-1:0]      data_in;
    logic [CAP-1:0]       sw_in;
    logic                 sw_load;
    logic                 sw_busy;
    logic                 sw_err;
    logic [CAP-1:0]       sw_active;
    logic [W*CAP-1:0]     data_out_FF;

    cap_switch_router #(
        .WIDTH(W), .CHANNEL_NUM(CN), .CAPACITOR_NUM(CAP), .BBM_CYCLES(B)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .sw_in(sw_in),
        .sw_load(sw_load), .sw_busy(sw_busy), .sw_err(sw_err),
        .sw_active(sw_active), .data_out_FF(data_out_FF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W*CAP-1:0] d;
        logic             busy;
        logic             err;
        logic [CAP-1:0]   act;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state: mask in force, pending mask, and the number of
    // edges since the last accepted load (-1 when no reconfiguration).
    logic [CAP-1:0] m_mask;
    logic [CAP-1:0] m_new;
    int             m_since;

    function automatic logic [W*CAP-1:0] route(input logic [CAP-1:0] mask,
                                               input logic [W*CN-1:0] din);
        logic [W*CAP-1:0] o;
        int k;
        o = '0;
        k = 0;
        for (int j = 0; j < CAP; j++) begin
            if (mask[j]) begin
                o[j*W +: W] = din[k*W +: W];
                k++;
            end
        end
        return o;
    endfunction

    task automatic model_reset();
        m_mask  = LOWER;
        m_new   = LOWER;
        m_since = -1;
    endtask

    // Drive one cycle of inputs and queue the response expected after the edge
    task automatic step(input logic ld, input logic [CAP-1:0] m, input bit rnd);
        exp_t e;
        logic idle_pre;
        logic ok;
        int   sn;
        @(negedge clk);
        for (int c = 0; c < CN; c++)
            data_in[c*W +: W] = rnd ? W'($urandom) : W'(c);
        sw_load = ld;
        sw_in   = ld ? m : {$urandom, $urandom, $urandom, $urandom};
        ok       = ($countones(sw_in) == CN);
        idle_pre = (m_since == -1) || (m_since == B + 1);
        e.err    = idle_pre && ld && !ok;
        if (idle_pre) begin
            e.d = route(m_mask, data_in);
            sn  = (ld && ok) ? 0 : -1;
            if (sn == 0) m_new = sw_in;
        end else begin
            e.d = '0;
            sn  = m_since + 1;
            if (sn == B + 1) m_mask = m_new;
        end
        m_since = sn;
        e.busy  = (sn >= 0);
        e.act   = m_mask;
        q.push_back(e);
    endtask

    task automatic drain(input bit rnd);
        repeat (B + 4) step(1'b0, '0, rnd);
    endtask

    task automatic check_rst(input string tag);
        total += 4;
        if (data_out_FF !== '0) begin
            bad++; $display("FAIL %s data got=%h exp=0", tag, data_out_FF[63:0]);
        end
        if (sw_busy !== 1'b0) begin
            bad++; $display("FAIL %s busy got=%b exp=0", tag, sw_busy);
        end
        if (sw_err !== 1'b0) begin
            bad++; $display("FAIL %s err got=%b exp=0", tag, sw_err);
        end
        if (sw_active !== LOWER) begin
            bad++; $display("FAIL %s active got=%h exp=%h", tag, sw_active, LOWER);
        end
    endtask

    // Monitor: compare every registered output once per cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                total += 4;
                if (data_out_FF !== e.d) begin
                    bad++;
                    for (int j = 0; j < CAP; j++) begin
                        if (data_out_FF[j*W +: W] !== e.d[j*W +: W]) begin
                            $display("FAIL data cyc=%0d slot=%0d got=%h exp=%h",
                                     cyc, j, data_out_FF[j*W +: W], e.d[j*W +: W]);
                            break;
                        end
                    end
                end
                if (sw_busy !== e.busy) begin
                    bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, sw_busy, e.busy);
                end
                if (sw_err !== e.err) begin
                    bad++; $display("FAIL err cyc=%0d got=%b exp=%b", cyc, sw_err, e.err);
                end
                if (sw_active !== e.act) begin
                    bad++; $display("FAIL active cyc=%0d got=%h exp=%h", cyc, sw_active, e.act);
                end
            end
        end
    end

    initial begin
        logic [CAP-1:0] upper, m69, il, rm;
        rst_n   = 1'b0;
        data_in = '0;
        sw_in   = '0;
        sw_load = 1'b0;
        model_reset();
        upper = LOWER << (CAP - CN);
        m69   = LOWER >> 1;
        il    = '0;
        for (int i = 0; i < CAP; i += 2) il[i] = 1'b1;
        for (int i = 1; i <= 11; i += 2) il[i] = 1'b1;

        #12;
        check_rst("reset");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Default lower-70 routing, channel i = i
        repeat (3) step(1'b0, '0, 1'b0);

        // Upper-70 mask with full break-before-make
        step(1'b1, upper, 1'b0);
        drain(1'b0);

        // Invalid popcounts, including back-to-back rejects
        step(1'b1, m69, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b1, m69, 1'b1);
        step(1'b1, {CAP{1'b1}}, 1'b1);
        repeat (2) step(1'b0, '0, 1'b1);

        // Second load while breaking is ignored
        step(1'b1, LOWER, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, upper, 1'b1);
        drain(1'b1);

        // Identical-mask reload still runs the full sequence
        step(1'b1, LOWER, 1'b1);
        drain(1'b1);

        // Interleaved mask under random data
        step(1'b1, il, 1'b1);
        drain(1'b1);
        repeat (1000) step(1'b0, '0, 1'b1);

        // Random valid masks
        repeat (8) begin
            rm = '0;
            while ($countones(rm) < CN) rm[$urandom_range(CAP - 1)] = 1'b1;
            step(1'b1, rm, 1'b1);
            drain(1'b1);
            repeat ($urandom_range(5)) step(1'b0, '0, 1'b1);
        end

        // Asynchronous reset in the middle of BREAK
        step(1'b1, upper, 1'b1);
        repeat (2) step(1'b0, '0, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_rst("midbreak");
        q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (4) step(1'b0, '0, 1'b0);
        repeat (4) step(1'b0, '0, 1'b1);

        // Let the monitor consume remaining expectations (bounded)
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
